// File: rtl/display_serializer.sv
// rtl/display_serializer.sv - snapshot display registers and shift them out as a 64-bit framed serial word
//
// Ports:
//   clock, reset (async, active low)
//   load                      one-cycle strobe: capture the inputs below and send a frame
//   AVS/DAY/MAX/TIM/col/point mode and segment flags packed into the header byte
//   upper10..lower0001        six ASCII characters, sent in that order after the header
//   cs_n, sclk, sdata         3-wire link to the LCD controller, MSB first, data moves on sclk fall
//   busy                      frame in progress (start through end of inter-frame gap)
//   done                      one-cycle pulse coincident with cs_n rising
//   overrun                   sticky; a queued frame was overwritten before it was sent

module display_serializer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       AVS,
    input  logic       DAY,
    input  logic       MAX,
    input  logic       TIM,
    input  logic       col,
    input  logic       point,
    input  logic [7:0] upper10,
    input  logic [7:0] upper01,
    input  logic [7:0] lower1000,
    input  logic [7:0] lower0100,
    input  logic [7:0] lower0010,
    input  logic [7:0] lower0001,
    output logic       cs_n,
    output logic       sclk,
    output logic       sdata,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, GAP} state_t;

    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

    state_t      state, state_nx;
    logic [63:0] shreg, shreg_nx;
    logic [63:0] pend, pend_nx;
    logic        pend_vld, pend_vld_nx;
    logic [5:0]  bit_cnt, bit_cnt_nx;
    logic [8:0]  div_cnt, div_cnt_nx;
    logic        cs_n_nx, sclk_nx, busy_nx, done_nx, overrun_nx;

    logic [7:0]  hdr;
    logic [63:0] frame_in;

    assign hdr      = {2'b10, col, point, AVS, DAY, MAX, TIM};
    assign frame_in = {hdr, upper10, upper01, lower1000, lower0100, lower0010, lower0001,
                       hdr ^ upper10 ^ upper01 ^ lower1000 ^ lower0100 ^ lower0010 ^ lower0001};

    // The shift register's MSB is the line; it is zeroed at frame end so sdata idles low.
    assign sdata = shreg[63];

    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        pend_nx     = pend;
        pend_vld_nx = pend_vld;
        bit_cnt_nx  = bit_cnt;
        div_cnt_nx  = div_cnt;
        cs_n_nx     = cs_n;
        sclk_nx     = sclk;
        busy_nx     = busy;
        done_nx     = 1'b0;
        overrun_nx  = overrun;

        case (state)
            IDLE: begin
                if (pend_vld || load) begin
                    state_nx   = SHIFT_LO;
                    cs_n_nx    = 1'b0;
                    sclk_nx    = 1'b0;
                    bit_cnt_nx = 6'd63;
                    div_cnt_nx = 9'd0;
                    busy_nx    = 1'b1;
                    if (pend_vld) begin
                        // Queued frame goes first; a simultaneous load refills the queue.
                        shreg_nx    = pend;
                        pend_vld_nx = load;
                        if (load) pend_nx = frame_in;
                    end else begin
                        shreg_nx = frame_in;
                    end
                end
            end
            SHIFT_LO: begin
                if (div_cnt == HALF_LAST) begin
                    sclk_nx    = 1'b1;
                    div_cnt_nx = 9'd0;
                    state_nx   = SHIFT_HI;
                end else begin
                    div_cnt_nx = div_cnt + 9'd1;
                end
            end
            SHIFT_HI: begin
                if (div_cnt == HALF_LAST) begin
                    sclk_nx    = 1'b0;
                    div_cnt_nx = 9'd0;
                    if (bit_cnt == 6'd0) begin
                        cs_n_nx  = 1'b1;
                        shreg_nx = '0;
                        done_nx  = 1'b1;
                        state_nx = GAP;
                    end else begin
                        shreg_nx   = {shreg[62:0], 1'b0};
                        bit_cnt_nx = bit_cnt - 6'd1;
                        state_nx   = SHIFT_LO;
                    end
                end else begin
                    div_cnt_nx = div_cnt + 9'd1;
                end
            end
            GAP: begin
                if (div_cnt == GAP_LAST) begin
                    div_cnt_nx = 9'd0;
                    busy_nx    = 1'b0;
                    state_nx   = IDLE;
                end else begin
                    div_cnt_nx = div_cnt + 9'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Any load outside IDLE (including the last GAP cycle) lands in the queue.
        if (state != IDLE && load) begin
            pend_nx     = frame_in;
            pend_vld_nx = 1'b1;
            if (pend_vld) overrun_nx = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            bit_cnt  <= 6'd0;
            div_cnt  <= 9'd0;
            cs_n     <= 1'b1;
            sclk     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            pend     <= pend_nx;
            pend_vld <= pend_vld_nx;
            bit_cnt  <= bit_cnt_nx;
            div_cnt  <= div_cnt_nx;
            cs_n     <= cs_n_nx;
            sclk     <= sclk_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            overrun  <= overrun_nx;
        end
    end

endmodule

// File: doc/display_serializer.md
Name: display_serializer

Overview:
- Reads the display-register set produced by the control block and ships it to the off-chip LCD controller over a 3-wire serial link (cs_n, sclk, sdata).
- The control block only writes the register set; this block snapshots it on a strobe, frames it, adds a checksum, and shifts it out MSB first.
- It sits between the control block outputs and the top-level display pins.

Parameters:
CLK_DIV, 4, sclk half-period in clock cycles; legal range is 1..255.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
load  in  1  one-cycle strobe; snapshot the inputs below and send a frame
AVS  in  1  mode flag
DAY  in  1  mode flag
MAX  in  1  mode flag
TIM  in  1  mode flag
col  in  1  colon segment
point  in  1  decimal point segment
upper10  in  8  ASCII character
upper01  in  8  ASCII character
lower1000  in  8  ASCII character
lower0100  in  8  ASCII character
lower0010  in  8  ASCII character
lower0001  in  8  ASCII character
cs_n  out  1  frame select, active low
sclk  out  1  serial clock, idle low
sdata  out  1  serial data; changes on the sclk falling edge
busy  out  1  high from the cycle after an accepted load until the FSM returns to IDLE
done  out  1  one-cycle pulse in the cycle cs_n rises
overrun  out  1  sticky; set when load overwrites an unsent pending frame

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - cs_n=1, sclk=0, sdata=0, busy=0, done=0, overrun=0.
  - pending empty, FSM in IDLE.
  - Deassertion of reset is synchronous to clock.
- Frame: 64 bits, sent MSB first, in this byte order:
  - B0 = {1'b1, 1'b0, col, point, AVS, DAY, MAX, TIM}
  - B1 = upper10, B2 = upper01, B3 = lower1000, B4 = lower0100, B5 = lower0010, B6 = lower0001
  - B7 = B0^B1^B2^B3^B4^B5^B6
- Snapshot: the frame is built from the inputs sampled in the load cycle. Later input changes do not affect a frame already captured.
- States and transitions:
  - IDLE:
    - If pending is valid, load it; else if load=1, load the sampled inputs. Pending takes priority. When both occur in the same cycle, the new load goes to pending.
    - On start, next cycle: cs_n=0, sdata=bit63, sclk=0, bit_cnt=63, div_cnt=0, busy=1; go to SHIFT_LO.
  - SHIFT_LO:
    - sclk=0. When div_cnt==CLK_DIV-1: sclk<=1, div_cnt<=0, go to SHIFT_HI. Otherwise div_cnt++.
  - SHIFT_HI:
    - sclk=1. When div_cnt==CLK_DIV-1: sclk<=0 and div_cnt<=0, then:
      - If bit_cnt==0: cs_n<=1, sdata<=0, done<=1, go to GAP.
      - Else: shift, sdata<=next bit, bit_cnt--, go to SHIFT_LO.
  - GAP:
    - cs_n=1, sclk=0. Hold for 2*CLK_DIV cycles, then go to IDLE with busy<=0.
- Timing:
  - cs_n is low for exactly 128*CLK_DIV cycles.
  - Each bit is valid for 2*CLK_DIV cycles and is stable across the sclk rising edge.
- Load while busy:
  - The frame is captured into a single-entry pending buffer.
  - A further load while pending is still valid overwrites it and sets overrun.
  - overrun clears only on reset.
  - The pending frame starts one cycle after IDLE is re-entered.
- load in the same cycle as the FSM returns to IDLE: treated as a load while busy, so it goes to pending and starts on the next cycle.
- Reset mid-frame: the frame is abandoned immediately. cs_n=1, sclk=0, and pending is cleared. No done pulse is generated.
- CLK_DIV=1: sclk toggles every cycle. All rules above still hold.

Test Plan:
- Basic frame, CLK_DIV=2:
  - Stimulus: DAY=1, point=1, upper=0x20/0x20, lower=0x30/0x31/0x32/0x33, one load pulse.
  - Required: captured bytes 94 20 20 30 31 32 33 94; cs_n low for 256 cycles; done high for 1 cycle as cs_n rises; busy=0 after 4 gap cycles.
- Bit timing, CLK_DIV=3:
  - Required: sclk high 3 cycles and low 3 cycles; sdata changes only on falling edges; 64 rising edges per frame.
- Back-to-back loads:
  - Stimulus: a second load at cycle 50 of a frame, with TIM=1, col=1.
  - Required: second frame B0=0xA1; it starts 1 cycle after IDLE; overrun=0.
- Overrun:
  - Stimulus: three loads during one frame, with lower0001 = 0x31, 0x32, 0x33 respectively.
  - Required: frame 2 carries lower0001=0x33; overrun=1 and stays 1.
- Snapshot isolation:
  - Stimulus: change all inputs the cycle after load.
  - Required: the transmitted frame matches the load-cycle values.
- Reset mid-frame:
  - Stimulus: assert reset at bit 20 with a pending frame queued.
  - Required: cs_n=1 and sclk=0 asynchronously; no done pulse; after release, no frame is sent without a new load.
